glitch_sweep_ctrl: RTL and testbench

GLITCH_SWEEP_CTRL -- requirements
Module: glitch_sweep_ctrl

---
 rtl/glitch_sweep_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_glitch_sweep_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : glitch_sweep_ctrl
//  Brief    : Sweeps a 2-D (offset, duration) glitch parameter space. Each
//             attempt resets the target, arms the offset counter, waits for
//             the glitch window to close (or times out), settles, and then
//             hands the result out over a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module glitch_sweep_ctrl #(
    parameter int unsigned RST_CYCLES     = 10_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] ofs_start,
    input  logic [31:0] ofs_end,
    input  logic [31:0] ofs_step,
    input  logic [31:0] dur_start,
    input  logic [31:0] dur_end,
    input  logic [31:0] dur_step,
    input  logic [31:0] settle_cycles,
    input  logic        glitch_done,
    output logic        target_reset,
    output logic        start_offset_counter,
    output logic [31:0] offset,
    output logic [31:0] duration,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_ofs,
    output logic [31:0] res_dur,
    output logic        res_timeout,
    output logic        busy,
    output logic        sweep_done
);

    // A zero-length hold/timeout makes no sense; treat it as one cycle.
    localparam int unsigned c_RST_EFF  = (RST_CYCLES == 0) ? 1 : RST_CYCLES;
    localparam int unsigned c_TO_EFF   = (TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES;
    localparam logic [31:0] c_RST_LAST = 32'(c_RST_EFF - 1);
    localparam logic [31:0] c_TO_LAST  = 32'(c_TO_EFF - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_ARM    = 3'd2,
        S_WAIT   = 3'd3,
        S_SETTLE = 3'd4,
        S_REPORT = 3'd5,
        S_NEXT   = 3'd6
    } state_t;

    state_t      r_state;
    logic [31:0] r_cnt;

    // Bounds captured at start; ofs_start needs no copy because it is loaded
    // straight into r_offset and never needed again.
    logic [31:0] r_ofs_end;
    logic [31:0] r_ofs_step;
    logic [31:0] r_dur_start;
    logic [31:0] r_dur_end;
    logic [31:0] r_dur_step;
    logic [31:0] r_settle;

    logic [31:0] r_offset;
    logic [31:0] r_duration;
    logic        r_target_reset;
    logic        r_soc;
    logic        r_res_valid;
    logic [31:0] r_res_ofs;
    logic [31:0] r_res_dur;
    logic        r_res_timeout;
    logic        r_busy;
    logic        r_sweep_done;

    logic [31:0] w_dur_step_eff;
    logic [31:0] w_ofs_step_eff;
    logic [32:0] w_dur_next;
    logic [32:0] w_ofs_next;
    logic        w_dur_over;
    logic        w_ofs_over;
    logic        w_bounds_bad;

    // Next-point arithmetic in 33 bits so a carry-out always reads as "past the end".
    always_comb begin
        w_dur_step_eff = (r_dur_step == 32'd0) ? 32'd1 : r_dur_step;
        w_ofs_step_eff = (r_ofs_step == 32'd0) ? 32'd1 : r_ofs_step;
        w_dur_next     = {1'b0, r_duration} + {1'b0, w_dur_step_eff};
        w_ofs_next     = {1'b0, r_offset} + {1'b0, w_ofs_step_eff};
        w_dur_over     = (w_dur_next > {1'b0, r_dur_end});
        w_ofs_over     = (w_ofs_next > {1'b0, r_ofs_end});
        w_bounds_bad   = (ofs_start > ofs_end) || (dur_start > dur_end);
    end

    // Sweep sequencer; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= 32'd0;
            r_ofs_end      <= 32'd0;
            r_ofs_step     <= 32'd0;
            r_dur_start    <= 32'd0;
            r_dur_end      <= 32'd0;
            r_dur_step     <= 32'd0;
            r_settle       <= 32'd0;
            r_offset       <= 32'd0;
            r_duration     <= 32'd0;
            r_target_reset <= 1'b0;
            r_soc          <= 1'b0;
            r_res_valid    <= 1'b0;
            r_res_ofs      <= 32'd0;
            r_res_dur      <= 32'd0;
            r_res_timeout  <= 1'b0;
            r_busy         <= 1'b0;
            r_sweep_done   <= 1'b0;
        end else begin
            r_soc        <= 1'b0;
            r_sweep_done <= 1'b0;
            if (abort && (r_state != S_IDLE)) begin
                // Abort beats everything, including a same-cycle handshake.
                r_state        <= S_IDLE;
                r_target_reset <= 1'b0;
                r_res_valid    <= 1'b0;
                r_busy         <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            r_ofs_end   <= ofs_end;
                            r_ofs_step  <= ofs_step;
                            r_dur_start <= dur_start;
                            r_dur_end   <= dur_end;
                            r_dur_step  <= dur_step;
                            r_settle    <= settle_cycles;
                            r_offset    <= ofs_start;
                            r_duration  <= dur_start;
                            if (w_bounds_bad) begin
                                r_sweep_done <= 1'b1;
                            end else begin
                                r_state        <= S_RESET;
                                r_target_reset <= 1'b1;
                                r_busy         <= 1'b1;
                                r_cnt          <= 32'd0;
                            end
                        end
                    end
                    S_RESET: begin
                        if (r_cnt == c_RST_LAST) begin
                            r_state        <= S_ARM;
                            r_target_reset <= 1'b0;
                            r_soc          <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    S_ARM: begin
                        r_state <= S_WAIT;
                        r_cnt   <= 32'd0;
                    end
                    S_WAIT: begin
                        if (glitch_done || (r_cnt == c_TO_LAST)) begin
                            // Payload is frozen here and not touched until the next attempt.
                            r_res_timeout <= ~glitch_done;
                            r_res_ofs     <= r_offset;
                            r_res_dur     <= r_duration;
                            r_cnt         <= 32'd0;
                            if (r_settle == 32'd0) begin
                                r_state     <= S_REPORT;
                                r_res_valid <= 1'b1;
                            end else begin
                                r_state <= S_SETTLE;
                            end
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    S_SETTLE: begin
                        if (r_cnt == (r_settle - 32'd1)) begin
                            r_state     <= S_REPORT;
                            r_res_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    S_REPORT: begin
                        if (res_ready) begin
                            r_res_valid <= 1'b0;
                            r_state     <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        if (!w_dur_over) begin
                            r_duration     <= w_dur_next[31:0];
                            r_state        <= S_RESET;
                            r_target_reset <= 1'b1;
                            r_cnt          <= 32'd0;
                        end else begin
                            r_duration <= r_dur_start;
                            if (!w_ofs_over) begin
                                r_offset       <= w_ofs_next[31:0];
                                r_state        <= S_RESET;
                                r_target_reset <= 1'b1;
                                r_cnt          <= 32'd0;
                            end else begin
                                r_state      <= S_IDLE;
                                r_busy       <= 1'b0;
                                r_sweep_done <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state        <= S_IDLE;
                        r_target_reset <= 1'b0;
                        r_res_valid    <= 1'b0;
                        r_busy         <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign target_reset         = r_target_reset;
    assign start_offset_counter = r_soc;
    assign offset               = r_offset;
    assign duration             = r_duration;
    assign res_valid            = r_res_valid;
    assign res_ofs              = r_res_ofs;
    assign res_dur              = r_res_dur;
    assign res_timeout          = r_res_timeout;
    assign busy                 = r_busy;
    assign sweep_done           = r_sweep_done;

endmodule
`default_nettype wire

// File: tb/tb_glitch_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_glitch_sweep_ctrl
//  Brief    : Self-checking bench for glitch_sweep_ctrl. Expected results come
//             from a nested-loop model of the sweep space.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_glitch_sweep_ctrl;

    localparam int RSTC = 4;
    localparam int TOC  = 16;

    logic        clk = 1'b0;
    logic        rst, start, abort, res_ready;
    logic        glitch_done = 1'b0;
    logic [31:0] ofs_start, ofs_end, ofs_step, dur_start, dur_end, dur_step, settle_cycles;
    logic        target_reset, start_offset_counter, res_valid, res_timeout, busy, sweep_done;
    logic [31:0] offset, duration, res_ofs, res_dur;

    int     n_checks = 0;
    int     n_err    = 0;
    longint cyc      = 0;

    glitch_sweep_ctrl #(.RST_CYCLES(RSTC), .TIMEOUT_CYCLES(TOC)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ofs_start(ofs_start), .ofs_end(ofs_end), .ofs_step(ofs_step),
        .dur_start(dur_start), .dur_end(dur_end), .dur_step(dur_step),
        .settle_cycles(settle_cycles), .glitch_done(glitch_done),
        .target_reset(target_reset), .start_offset_counter(start_offset_counter),
        .offset(offset), .duration(duration),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_ofs(res_ofs), .res_dur(res_dur), .res_timeout(res_timeout),
        .busy(busy), .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [64:0] exp_q[$];

    task automatic build_model(input longint os, input longint oe, input longint ost,
                               input longint ds, input longint de, input longint dst,
                               input bit to);
        longint so, sd;
        exp_q.delete();
        so = (ost == 0) ? 1 : ost;
        sd = (dst == 0) ? 1 : dst;
        if (os > oe || ds > de) return;
        for (longint o = os; o <= oe; o += so)
            for (longint d = ds; d <= de; d += sd)
                exp_q.push_back({o[31:0], d[31:0], to});
    endtask

    // ---------------- glitch source ----------------
    int gd_delay = 0;   // cycles after the arm pulse; 0 = never
    int gd_cnt   = 0;
    bit gd_noise = 0;   // also pulse during target reset, which must be ignored

    always @(negedge clk) begin
        bit hit;
        hit = 1'b0;
        if (gd_cnt > 0) begin
            gd_cnt--;
            hit = (gd_cnt == 0);
        end
        if (start_offset_counter && gd_delay > 0) gd_cnt = gd_delay;
        glitch_done = hit || (gd_noise && target_reset);
    end

    // ---------------- observation ----------------
    logic [64:0] got_q[$];
    int          lat_q[$];
    int          n_sdone = 0, n_soc = 0, stab_err = 0;
    longint      t_rst = 0;
    logic        prev_valid = 0, prev_hs = 0, prev_abort = 0, prev_tr = 0;
    logic [64:0] prev_pay = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 0; prev_hs = 0; prev_tr = 0;
        end else begin
            if (prev_valid && !prev_hs && !prev_abort &&
                (!res_valid || {res_ofs, res_dur, res_timeout} !== prev_pay)) stab_err++;
            if (target_reset && !prev_tr) t_rst = cyc;
            if (res_valid && !prev_valid) lat_q.push_back(int'(cyc - t_rst));
            if (res_valid && res_ready) got_q.push_back({res_ofs, res_dur, res_timeout});
            if (sweep_done) n_sdone++;
            if (start_offset_counter) n_soc++;
            prev_valid = res_valid;
            prev_hs    = res_valid && res_ready;
            prev_abort = abort;
            prev_pay   = {res_ofs, res_dur, res_timeout};
            prev_tr    = target_reset;
        end
    end

    // ---------------- stimulus helpers ----------------
    bit rdy_rand = 0;

    task automatic set_bounds(input logic [31:0] os, input logic [31:0] oe, input logic [31:0] ost,
                              input logic [31:0] ds, input logic [31:0] de, input logic [31:0] dst,
                              input logic [31:0] st);
        ofs_start = os; ofs_end = oe; ofs_step = ost;
        dur_start = ds; dur_end = de; dur_step = dst; settle_cycles = st;
    endtask

    task automatic clear_mon();
        got_q.delete(); lat_q.delete();
        n_sdone = 0; n_soc = 0; stab_err = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (k < budget) begin
            @(posedge clk); #1;
            if (rdy_rand) res_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!busy) break;
            k++;
        end
        check({tag, "_finished"}, 128'(k < budget), 128'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k = 0;
        @(negedge clk);
        while (!res_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_valid_seen"}, 128'(k < budget), 128'd1);
    endtask

    task automatic compare_results(input string tag);
        check({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_res%0d", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_flags"}, 128'({target_reset, start_offset_counter, res_valid,
                                      res_timeout, busy, sweep_done}), 128'd0);
        check({tag, "_offset"}, 128'(offset), 128'd0);
        check({tag, "_duration"}, 128'(duration), 128'd0);
        check({tag, "_res_ofs"}, 128'(res_ofs), 128'd0);
        check({tag, "_res_dur"}, 128'(res_dur), 128'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] os, oe, ost, ds, de, dst, st;

        rst = 0; start = 0; abort = 0; res_ready = 0;
        set_bounds(0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1;
        #1 check_zero("rst_async");
        repeat (3) @(posedge clk);
        @(negedge clk) check_zero("rst_hold");
        @(posedge clk); #1 rst = 0;
        repeat (2) @(negedge clk);
        check_zero("idle_no_start");

        // Basic 2x2 sweep; a second start with junk bounds mid-sweep must be ignored.
        set_bounds(10, 12, 2, 1, 2, 1, 3);
        build_model(10, 12, 2, 1, 2, 1, 0);
        gd_delay = 5; res_ready = 1; clear_mon();
        pulse_start();
        repeat (3) @(negedge clk);
        set_bounds(0, 100, 1, 0, 9, 1, 0);
        pulse_start();
        wait_idle("basic", 2000);
        compare_results("basic");
        check("basic_sweep_done", 128'(n_sdone), 128'd1);
        check("basic_arm_pulses", 128'(n_soc), 128'd4);
        check("basic_stable", 128'(stab_err), 128'd0);

        // Timeout path; glitch pulses during target reset must not count.
        set_bounds(10, 12, 2, 1, 2, 1, 3);
        build_model(10, 12, 2, 1, 2, 1, 1);
        gd_delay = 0; gd_noise = 1; clear_mon();
        pulse_start();
        wait_idle("tmo", 2000);
        gd_noise = 0;
        compare_results("tmo");
        check("tmo_sweep_done", 128'(n_sdone), 128'd1);
        check("tmo_lat_count", 128'(lat_q.size()), 128'd4);
        for (int i = 0; i < lat_q.size(); i++)
            check($sformatf("tmo_latency%0d", i), 128'(lat_q[i]), 128'(RSTC + 1 + TOC + 3));

        // Backpressure: ready low for 20 cycles, zero settle.
        set_bounds(7, 7, 1, 3, 4, 1, 0);
        build_model(7, 7, 1, 3, 4, 1, 0);
        gd_delay = 5; res_ready = 0; clear_mon();
        pulse_start();
        wait_valid("bp", 200);
        repeat (20) @(negedge clk);
        check("bp_valid_held", 128'(res_valid), 128'd1);
        check("bp_payload", 128'({res_ofs, res_dur, res_timeout}), 128'({32'd7, 32'd3, 1'b0}));
        check("bp_stable", 128'(stab_err), 128'd0);
        @(posedge clk); #1 res_ready = 1;
        @(negedge clk) check("bp_hs_valid", 128'(res_valid), 128'd1);
        @(negedge clk) check("bp_next_state", 128'({res_valid, busy, target_reset}), 128'(3'b010));
        @(negedge clk) check("bp_advance", 128'({target_reset, offset, duration}),
                             128'({1'b1, 32'd7, 32'd4}));
        wait_idle("bp", 2000);
        compare_results("bp");

        // Duration near 2^32: carry must end the row after one attempt.
        set_bounds(5, 5, 0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 2, 1);
        build_model(5, 5, 0, 64'hFFFF_FFFE, 64'hFFFF_FFFF, 2, 0);
        clear_mon();
        pulse_start();
        wait_idle("wrap", 2000);
        compare_results("wrap");
        check("wrap_sweep_done", 128'(n_sdone), 128'd1);

        // Empty range: immediate sweep_done, no attempt.
        set_bounds(10, 5, 1, 1, 1, 1, 0);
        clear_mon();
        pulse_start();
        @(negedge clk) check("empty_done", 128'({sweep_done, busy, target_reset}), 128'(3'b100));
        repeat (RSTC + 3) @(negedge clk);
        check("empty_no_attempt", 128'({n_sdone, n_soc}), 128'({32'd1, 32'd0}));

        // Start together with abort while idle is ignored.
        set_bounds(1, 2, 1, 1, 1, 1, 0);
        clear_mon();
        @(posedge clk); #1 start = 1; abort = 1;
        @(posedge clk); #1 start = 0; abort = 0;
        repeat (3) @(negedge clk);
        check("start_abort_idle", 128'({busy, target_reset, 32'(n_sdone)}), 128'd0);

        // Abort during RESET.
        clear_mon();
        pulse_start();
        @(negedge clk) check("abort_rst_in_reset", 128'(target_reset), 128'd1);
        @(posedge clk); #1 abort = 1;
        @(posedge clk); #1 abort = 0;
        @(negedge clk) check("abort_rst_next", 128'({target_reset, busy}), 128'd0);
        repeat (RSTC + 5) @(negedge clk);
        check("abort_rst_quiet", 128'({n_sdone, n_soc}), 128'd0);

        // Abort coinciding with a REPORT handshake.
        set_bounds(1, 1, 1, 1, 3, 1, 1);
        res_ready = 0; clear_mon();
        pulse_start();
        wait_valid("abort_rep", 200);
        @(posedge clk); #1 abort = 1; res_ready = 1;
        @(posedge clk); #1 abort = 0; res_ready = 0;
        @(negedge clk) check("abort_rep_next", 128'({res_valid, target_reset, busy}), 128'd0);
        repeat (RSTC + 5) @(negedge clk);
        check("abort_rep_no_done", 128'(n_sdone), 128'd0);
        check("abort_rep_consumed", 128'(got_q.size()), 128'd1);
        check("abort_rep_idle", 128'(busy), 128'd0);

        // Asynchronous reset in WAIT, then restart.
        set_bounds(20, 22, 1, 5, 5, 1, 2);
        gd_delay = 0; res_ready = 1; clear_mon();
        pulse_start();
        begin
            int k = 0;
            while (!start_offset_counter && k < 100) begin
                @(negedge clk);
                k++;
            end
            check("rstwait_armed", 128'(k < 100), 128'd1);
        end
        repeat (3) @(negedge clk);
        #2 rst = 1;
        #1 check_zero("rstwait_async");
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        @(negedge clk) check("rstwait_restart", 128'({busy, target_reset, offset, duration}),
                             128'({1'b1, 1'b1, 32'd20, 32'd5}));
        @(posedge clk); #1 abort = 1;
        @(posedge clk); #1 abort = 0;
        @(negedge clk) check("rstwait_cleanup", 128'(busy), 128'd0);

        // Randomized sweeps with random ready and glitch timing.
        for (int it = 0; it < 4; it++) begin
            os  = $urandom_range(0, 1000);
            ost = $urandom_range(0, 3);
            oe  = os + $urandom_range(0, 5);
            ds  = $urandom_range(0, 1000);
            dst = $urandom_range(0, 3);
            de  = ds + $urandom_range(0, 4);
            st  = $urandom_range(0, 4);
            gd_delay = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
            set_bounds(os, oe, ost, ds, de, dst, st);
            build_model(os, oe, ost, ds, de, dst, gd_delay == 0);
            rdy_rand = 1; gd_noise = 1; clear_mon();
            pulse_start();
            wait_idle($sformatf("rand%0d", it), 6000);
            compare_results($sformatf("rand%0d", it));
            check($sformatf("rand%0d_sweep_done", it), 128'(n_sdone), 128'd1);
            check($sformatf("rand%0d_stable", it), 128'(stab_err), 128'd0);
        end
        rdy_rand = 0; gd_noise = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
